// File: rtl/cbus_pkg.sv
// cbus_pkg: shared types for the cached-bus (cbus) request/response channel.
//   cbus_burst_e : burst kind (FIXED, INCR, WRAP; value 3 is reserved)
//   cbus_req_t   : initiator request (valid, is_write, size, addr, strobe,
//                  data, len = beats-1, burst)
//   cbus_resp_t  : responder reply (ready, last, data)
package cbus_pkg;

  typedef enum logic [1:0] {
    CBUS_FIXED = 2'd0,
    CBUS_INCR  = 2'd1,
    CBUS_WRAP  = 2'd2,
    CBUS_RSVD  = 2'd3
  } cbus_burst_e;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
    cbus_burst_e burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_mem_responder.sv
// cbus_mem_responder: memory-side responder for the cbus protocol. Serves
// single-word and burst reads/writes from an internal word-addressed memory
// of 2^ADDR_WIDTH 32-bit words, with a fixed first-beat latency.
//
// Parameters:
//   ADDR_WIDTH : word-index bits (memory depth 2^ADDR_WIDTH words)
//   LATENCY    : idle cycles between request acceptance and first beat (0..15)
// Ports:
//   clk       : clock, all state updates on the rising edge
//   reset     : asynchronous active-high reset
//   creq      : initiator request (cbus_req_t)
//   cresp     : response (cbus_resp_t); ready completes a beat, last marks
//               the final beat and is only high together with ready
//   proto_err : sticky, set when creq.valid drops mid-transaction
module cbus_mem_responder
  import cbus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LATENCY    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp,
  output logic       proto_err
);

  typedef logic [ADDR_WIDTH-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    RECOVER
  } state_e;

  localparam logic [3:0] LAT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e      state_q, state_d;
  logic        is_write_q, is_write_d;
  idx_t        idx_q, idx_d, idx_next;
  logic [3:0]  len_q, len_d;
  cbus_burst_e burst_q, burst_d;
  logic [3:0]  beat_q, beat_d;
  logic [3:0]  lat_q, lat_d;
  logic        proto_err_q, proto_err_d;
  logic        mem_we;
  logic        wrap_ok;
  idx_t        wrap_mask;

  logic [31:0] mem [2**ADDR_WIDTH];

  // Address bits below the word and above the index, and size, are ignored.
  logic unused_req_bits;
  assign unused_req_bits = ^{creq.size, creq.addr};

  // Next beat index. WRAP keeps the upper bits of the (len+1)-aligned block
  // and increments only the low bits under the mask; it is only meaningful
  // when len+1 is a power of two (len in 1,3,7,15), else it acts as INCR.
  always_comb begin
    wrap_ok   = (len_q != 4'd0) && ((len_q & (len_q + 4'd1)) == 4'd0);
    wrap_mask = idx_t'(len_q);
    case (burst_q)
      CBUS_FIXED: idx_next = idx_q;
      CBUS_WRAP:  idx_next = wrap_ok ? ((idx_q & ~wrap_mask) | ((idx_q + 1'b1) & wrap_mask))
                                     : idx_q + 1'b1;
      default:    idx_next = idx_q + 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    idx_d       = idx_q;
    len_d       = len_q;
    burst_d     = burst_q;
    beat_d      = beat_q;
    lat_d       = lat_q;
    proto_err_d = proto_err_q;
    mem_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (creq.valid) begin
          is_write_d = creq.is_write;
          idx_d      = creq.addr[ADDR_WIDTH+1:2];
          len_d      = creq.len;
          burst_d    = creq.burst;
          beat_d     = '0;
          if (LATENCY > 0) begin
            state_d = WAIT;
            lat_d   = LAT_INIT;
          end else begin
            state_d = BURST;
          end
        end
      end
      WAIT: begin
        if (!creq.valid) begin
          proto_err_d = 1'b1;
          state_d     = IDLE;
        end else if (lat_q == '0) begin
          state_d = BURST;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      BURST: begin
        if (!creq.valid) begin
          proto_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          mem_we = is_write_q;
          if (beat_q == len_q) begin
            state_d = RECOVER;
          end else begin
            beat_d = beat_q + 4'd1;
            idx_d  = idx_next;
          end
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      is_write_q  <= 1'b0;
      idx_q       <= '0;
      len_q       <= '0;
      burst_q     <= CBUS_FIXED;
      beat_q      <= '0;
      lat_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      burst_q     <= burst_d;
      beat_q      <= beat_d;
      lat_q       <= lat_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Memory contents are never reset. Writes are gated by state, so a beat
  // cut short by an asynchronous reset is never committed.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (creq.strobe[i]) mem[idx_q][8*i +: 8] <= creq.data[8*i +: 8];
      end
    end
  end

  // Response is decoded from registered state only, so reset clears it at once.
  always_comb begin
    cresp = '0;
    if (state_q == BURST) begin
      cresp.ready = 1'b1;
      cresp.last  = (beat_q == len_q);
      cresp.data  = is_write_q ? '0 : mem[idx_q];
    end
  end

  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_cbus_mem_responder.sv
// tb_cbus_mem_responder: scoreboard bench for cbus_mem_responder. Stimulus
// computes each expected beat (cycle, last, data) from a word-array model and
// queues it; a negedge monitor pops and compares on every ready beat.
module tb_cbus_mem_responder;
  import cbus_pkg::*;

  localparam int LAT    = 2;
  localparam int AW     = 16;
  localparam int NWORDS = 1 << AW;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  logic       proto_err;

  cbus_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .creq      (creq),
    .cresp     (cresp),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          last;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] model_mem [int];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          ignore_beat = 1'b0;
  logic [31:0] txn_wd [16];
  logic [3:0]  txn_sb [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] need);
    n_checks++;
    if (act !== need) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, need 0x%0h (cycle %0d)", name, act, need, cyc);
    end
  endtask

  // Word visited on beat k, from the burst rules.
  function automatic int model_idx(input logic [31:0] addr, input int len, input int burst, input int k);
    int base, blk;
    base = int'((addr / 4) % NWORDS);
    blk  = len + 1;
    if (burst == 0) return base;
    if (burst == 2 && (blk == 2 || blk == 4 || blk == 8 || blk == 16))
      return (base - base % blk) + (base % blk + k) % blk;
    return (base + k) % NWORDS;
  endfunction

  function automatic void model_write(input int ix, input logic [31:0] d, input logic [3:0] sb);
    logic [31:0] w;
    if (model_mem.exists(ix)) begin
      w = model_mem[ix];
      for (int b = 0; b < 4; b++) if (sb[b]) w[8*b +: 8] = d[8*b +: 8];
      model_mem[ix] = w;
    end else if (sb == 4'hF) begin
      model_mem[ix] = d;
    end
  endfunction

  // Runs one transaction starting in the current cycle. stop_at >= 0 ends it
  // at that beat, either by dropping valid or (by_reset) by pulsing reset.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input int len, input int burst,
                         input int stop_at, input bit by_reset);
    int   t0, nb, ix, beat;
    exp_t e;
    nb = (stop_at >= 0) ? stop_at : len + 1;
    t0 = cyc;
    for (int k = 0; k < nb; k++) begin
      ix     = model_idx(addr, len, burst, k);
      e.cyc  = t0 + LAT + 1 + k;
      e.last = (k == len);
      if (wr) begin
        e.chk  = 1'b1;
        e.data = '0;
        model_write(ix, txn_wd[k], txn_sb[k]);
      end else begin
        e.chk  = model_mem.exists(ix);
        e.data = e.chk ? model_mem[ix] : '0;
      end
      exp_q.push_back(e);
    end
    creq.valid    = 1'b1;
    creq.is_write = wr;
    creq.size     = 3'd2;
    creq.addr     = addr;
    creq.len      = 4'(len);
    creq.burst    = cbus_burst_e'(burst);
    for (int c = 0; c <= LAT + 2 + len; c++) begin
      beat = c - (LAT + 1);
      if (stop_at >= 0 && beat == stop_at) begin
        if (by_reset) begin
          #1 reset = 1'b1;
          #1;
          check("reset_mid_ready", cresp.ready, 0);
          check("reset_mid_last", cresp.last, 0);
          check("reset_mid_data", cresp.data, 0);
          creq.valid = 1'b0;
          @(posedge clk);
          #1 reset = 1'b0;
          check("reset_mid_proto_err", proto_err, 0);
        end else begin
          creq.valid  = 1'b0;
          ignore_beat = 1'b1;
          @(posedge clk);
          #1 ignore_beat = 1'b0;
          check("abort_proto_err", proto_err, 1);
          check("abort_ready", cresp.ready, 0);
        end
        return;
      end
      if (beat >= 0 && beat <= len) begin
        creq.data   = txn_wd[beat];
        creq.strobe = txn_sb[beat];
      end else begin
        creq.data   = $urandom;
        creq.strobe = 4'($urandom);
      end
      @(posedge clk);
      #1;
    end
    creq.valid = 1'b0;
  endtask

  always @(negedge clk) begin
    check("last_without_ready", {63'd0, cresp.last & ~cresp.ready}, 0);
    if (!reset && cresp.ready && !ignore_beat) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready: ready=1 at cycle %0d, no beat expected", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("beat_last", cresp.last, mon_e.last);
        if (mon_e.chk) check("beat_data", cresp.data, mon_e.data);
      end
    end
  end

  initial begin
    logic [31:0] hi, a;
    int          ix, len, burst;
    bit          wr;
    reset = 1'b1;
    creq  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cresp", cresp, '0);
    check("reset_proto_err", proto_err, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single write then read, then partial-strobe merge.
    txn_wd[0] = 32'hDEADBEEF; txn_sb[0] = 4'hF;
    run_txn(1'b1, 32'h100, 0, 1, -1, 1'b0);
    run_txn(1'b0, 32'h100, 0, 1, -1, 1'b0);
    txn_wd[0] = 32'h12345678; txn_sb[0] = 4'h3;
    run_txn(1'b1, 32'h100, 0, 1, -1, 1'b0);
    run_txn(1'b0, 32'h100, 0, 1, -1, 1'b0);

    // 16-beat preload then back-to-back 16-beat INCR read.
    for (int k = 0; k < 16; k++) begin txn_wd[k] = 32'(k); txn_sb[k] = 4'hF; end
    run_txn(1'b1, 32'h200, 15, 1, -1, 1'b0);
    run_txn(1'b0, 32'h200, 15, 1, -1, 1'b0);

    // WRAP read C, D, A, B.
    txn_wd[0] = 32'hAAAA000A; txn_wd[1] = 32'hBBBB000B;
    txn_wd[2] = 32'hCCCC000C; txn_wd[3] = 32'hDDDD000D;
    run_txn(1'b1, 32'h100, 3, 1, -1, 1'b0);
    run_txn(1'b0, 32'h108, 3, 2, -1, 1'b0);

    // Mid-burst abort after beat 2.
    for (int k = 0; k < 8; k++) txn_wd[k] = 32'h11110000 + 32'(k);
    run_txn(1'b1, 32'h300, 7, 1, -1, 1'b0);
    for (int k = 0; k < 8; k++) txn_wd[k] = 32'h77770000 + 32'(k);
    run_txn(1'b1, 32'h300, 7, 1, 3, 1'b0);
    run_txn(1'b0, 32'h300, 7, 1, -1, 1'b0);
    check("proto_err_sticky", proto_err, 1);

    // Reset during beat 5 of a 16-beat read, then a fresh single read.
    run_txn(1'b0, 32'h200, 15, 1, 5, 1'b1);
    run_txn(1'b0, 32'h204, 0, 1, -1, 1'b0);

    // Fill words 0..511 through aliased addresses, then random traffic.
    for (int w = 0; w < 32; w++) begin
      for (int k = 0; k < 16; k++) begin txn_wd[k] = $urandom; txn_sb[k] = 4'hF; end
      hi = $urandom & 32'hFFFC0000;
      run_txn(1'b1, hi | 32'(w * 64), 15, 1, -1, 1'b0);
    end
    for (int t = 0; t < 60; t++) begin
      for (int k = 0; k < 16; k++) begin txn_wd[k] = $urandom; txn_sb[k] = 4'($urandom); end
      ix    = $urandom_range(0, 480);
      a     = ($urandom & 32'hFFFC0000) | 32'(ix * 4) | ($urandom & 32'h3);
      len   = $urandom_range(0, 15);
      burst = $urandom_range(0, 2);
      wr    = 1'($urandom_range(0, 1));
      run_txn(wr, a, len, burst, -1, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (LAT + 20) @(posedge clk);
    #1;
    check("pending_beats", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
